// File: rtl/score_scan_display_pkg.sv
// Segment encodings ({a,b,c,d,e,f,g}, 1 = lit) and the BCD decoder shared by the display.
// Pure combinational helpers: no latency and no flow control.
package score_disp_pkg;

   localparam logic [6:0] SEG_0    = 7'b1111110;
   localparam logic [6:0] SEG_1    = 7'b0110000;
   localparam logic [6:0] SEG_2    = 7'b1101101;
   localparam logic [6:0] SEG_3    = 7'b1111001;
   localparam logic [6:0] SEG_4    = 7'b0110011;
   localparam logic [6:0] SEG_5    = 7'b1011011;
   localparam logic [6:0] SEG_6    = 7'b1011111;
   localparam logic [6:0] SEG_7    = 7'b1110000;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1111011;
   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      case (bcd)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/score_scan_display_beep_stretcher.sv
// Beep pulse stretcher: rising edge of beep starts a BEEP_CYCLES buzzer burst one cycle later,
// retriggerable, no backpressure; BEEP_TONE_EN adds a TONE_HALF square-wave gate on the burst.
module beep_stretcher #(
   parameter int BEEP_CYCLES = 5000000,
   parameter int TONE_HALF   = 12500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic beep,
   output logic buzzer
);

   localparam int CW = $clog2(BEEP_CYCLES + 1);

   logic          beep_q;
   logic          rise;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          buz_nxt;

   assign rise = beep & ~beep_q;

   always_comb begin
      cnt_nxt = cnt;
      if (rise)
         cnt_nxt = CW'(BEEP_CYCLES);
      else if (cnt != '0)
         cnt_nxt = cnt - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beep_q <= 1'b0;
         cnt    <= '0;
         buzzer <= 1'b0;
      end else begin
         beep_q <= beep;
         cnt    <= cnt_nxt;
         buzzer <= buz_nxt;
      end
   end

`ifdef BEEP_TONE_EN
   localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

   logic [TW-1:0] tdiv;
   logic [TW-1:0] tdiv_nxt;
   logic          tone;
   logic          tone_nxt;

   // Divider only advances on cycles already inside a burst, so every burst opens with a low half.
   always_comb begin
      tdiv_nxt = tdiv;
      tone_nxt = tone;
      if (cnt_nxt == '0) begin
         tdiv_nxt = '0;
         tone_nxt = 1'b0;
      end else if (cnt != '0) begin
         if (tdiv == TW'(TONE_HALF - 1)) begin
            tdiv_nxt = '0;
            tone_nxt = ~tone;
         end else begin
            tdiv_nxt = tdiv + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tdiv <= '0;
         tone <= 1'b0;
      end else begin
         tdiv <= tdiv_nxt;
         tone <= tone_nxt;
      end
   end

   assign buz_nxt = tone_nxt & (cnt_nxt != '0);
`else
   assign buz_nxt = (cnt_nxt != '0);
`endif

endmodule

// File: rtl/score_scan_display.sv
// N-digit multiplexed 7-seg driver with frame snapshot, guard, LZ blanking, blink and buzzer (BEEP_TONE_EN = tone).
// seg/common/buzzer registered one cycle behind the prescaler; free-running, no backpressure.
module score_scan_display
   import score_disp_pkg::*;
#(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 64,
   parameter int BLINK_FRAMES = 64,
   parameter int BEEP_CYCLES  = 5000000,
   parameter int TONE_HALF    = 12500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] digits,
   input  logic                  blank_lz,
   input  logic [N_DIGITS-1:0]   blink_mask,
   input  logic                  beep,
   output logic [6:0]            seg,
   output logic [N_DIGITS-1:0]   common,
   output logic                  buzzer,
   output logic                  frame_tick
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(N_DIGITS);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]         presc;
   logic [SW-1:0]         slot;
   logic [4*N_DIGITS-1:0] snap_dig;
   logic [N_DIGITS-1:0]   snap_mask;
   logic [BW-1:0]         bcnt;
   logic                  hidden;
   logic                  presc_wrap;

   logic [3:0]            cur_dig;
   logic                  cur_blink;
   logic                  cur_lz;
   logic                  all_zero;
   logic [6:0]            seg_nxt;
   logic [N_DIGITS-1:0]   common_nxt;

   assign presc_wrap = (presc == PW'(SCAN_DIV - 1));
   assign frame_tick = presc_wrap && (slot == SW'(N_DIGITS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         slot      <= '0;
         snap_dig  <= '0;
         snap_mask <= '0;
         bcnt      <= '0;
         hidden    <= 1'b0;
         seg       <= SEG_OFF;
         common    <= '1;
      end else begin
         presc <= presc_wrap ? '0 : presc + 1'b1;
         if (presc_wrap)
            slot <= (slot == SW'(N_DIGITS - 1)) ? '0 : slot + 1'b1;
         // Inputs are only sampled at frame boundaries so a frame never mixes two scores.
         if (frame_tick) begin
            snap_dig  <= digits;
            snap_mask <= blink_mask;
            if (bcnt == BW'(BLINK_FRAMES - 1)) begin
               bcnt   <= '0;
               hidden <= ~hidden;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
         seg    <= seg_nxt;
         common <= common_nxt;
      end
   end

   always_comb begin
      cur_dig   = '0;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      all_zero  = 1'b1;
      // Walk from the most significant digit so all_zero means "this and every higher digit is 0".
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero && (snap_dig[4*i +: 4] == 4'd0);
         if (slot == SW'(i)) begin
            cur_dig   = snap_dig[4*i +: 4];
            cur_blink = snap_mask[i];
            cur_lz    = all_zero && (i != 0);
         end
      end

      seg_nxt = bcd_to_seg(cur_dig);
      if ((blank_lz && cur_lz) || (hidden && cur_blink))
         seg_nxt = SEG_OFF;

      common_nxt = '1;
      if (presc < PW'(GUARD))
         seg_nxt = SEG_OFF;
      else
         common_nxt[slot] = 1'b0;
   end

   beep_stretcher #(
      .BEEP_CYCLES (BEEP_CYCLES),
      .TONE_HALF   (TONE_HALF)
   ) u_beep (
      .clk    (clk),
      .rst_n  (rst_n),
      .beep   (beep),
      .buzzer (buzzer)
   );

endmodule

// File: tb/tb_score_scan_display.sv
// Bench for score_scan_display: cycle-count reference model feeds an expectation queue, a monitor pops and compares.
module tb_score_scan_display;

   localparam int N     = 4;
   localparam int SD    = 8;
   localparam int GD    = 2;
   localparam int BF    = 2;
   localparam int BC    = 10;
   localparam int TH    = 2;
   localparam int FRAME = N * SD;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [4*N-1:0] digits = '0;
   logic           blank_lz = 1'b0;
   logic [N-1:0]   blink_mask = '0;
   logic           beep = 1'b0;
   logic [6:0]     seg;
   logic [N-1:0]   common;
   logic           buzzer;
   logic           frame_tick;

   always #5 clk = ~clk;

   score_scan_display #(
      .N_DIGITS     (N),
      .SCAN_DIV     (SD),
      .GUARD        (GD),
      .BLINK_FRAMES (BF),
      .BEEP_CYCLES  (BC),
      .TONE_HALF    (TH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits     (digits),
      .blank_lz   (blank_lz),
      .blink_mask (blink_mask),
      .beep       (beep),
      .seg        (seg),
      .common     (common),
      .buzzer     (buzzer),
      .frame_tick (frame_tick)
   );

   typedef struct packed {
      logic [6:0]   seg;
      logic [N-1:0] common;
      logic         buzzer;
      logic         frame_tick;
   } obs_t;

   obs_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [6:0] ref_seg(input int v);
      case (v)
         0:       return 7'b1111110;
         1:       return 7'b0110000;
         2:       return 7'b1101101;
         3:       return 7'b1111001;
         4:       return 7'b0110011;
         5:       return 7'b1011011;
         6:       return 7'b1011111;
         7:       return 7'b1110000;
         8:       return 7'b1111111;
         9:       return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // Reference model: everything derived from k = clock edges since reset release.
   int             k;
   logic [4*N-1:0] m_dig;
   logic [N-1:0]   m_mask;
   int             remain;
   int             age;
   logic           beep_prev;

   always @(posedge clk) begin
      obs_t e;
      int   presc_v, slot_v, frames, dv;
      logic hide, lz;
      if (!rst_n) begin
         k = 0; m_dig = '0; m_mask = '0; remain = 0; age = 0; beep_prev = 1'b0;
         e.seg = 7'b0; e.common = '1; e.buzzer = 1'b0; e.frame_tick = 1'b0;
      end else begin
         k++;
         presc_v = (k - 1) % SD;
         slot_v  = ((k - 1) / SD) % N;
         frames  = (k - 1) / FRAME;
         hide    = ((frames / BF) % 2) == 1;
         dv      = int'(m_dig[4*slot_v +: 4]);
         lz      = (slot_v != 0) && ((m_dig >> (4*slot_v)) == 0);
         if (presc_v < GD) begin
            e.seg = 7'b0; e.common = '1;
         end else begin
            e.seg = ref_seg(dv);
            if ((blank_lz && lz) || (hide && m_mask[slot_v])) e.seg = 7'b0;
            e.common = ~(N'(1) << slot_v);
         end
         e.frame_tick = (k % FRAME) == FRAME - 1;
         if (k % FRAME == 0) begin
            m_dig  = digits;
            m_mask = blink_mask;
         end
         if (beep && !beep_prev) remain = BC;
         else if (remain > 0) remain--;
         if (remain > 0) age++;
         else age = 0;
`ifdef BEEP_TONE_EN
         e.buzzer = (remain > 0) && (((age - 1) / TH) % 2 == 1);
`else
         e.buzzer = (remain > 0);
`endif
         beep_prev = beep;
      end
      exp_q.push_back(e);
   end

   always begin
      obs_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if ({seg, common, buzzer, frame_tick} === e) n_pass++;
         else $display("FAIL outputs @%0t: seg=%b common=%b buzzer=%b frame_tick=%b, expected seg=%b common=%b buzzer=%b frame_tick=%b",
                       $time, seg, common, buzzer, frame_tick, e.seg, e.common, e.buzzer, e.frame_tick);
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [4*N-1:0] rand_digits();
      logic [4*N-1:0] d;
      int nz;
      d  = '0;
      nz = $urandom_range(0, N);
      for (int i = 0; i < N - nz; i++) d[4*i +: 4] = 4'($urandom_range(0, 15));
      return d;
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_seg", 32'(seg), 32'h0);
      check("rst_common", 32'(common), 32'hF);
      check("rst_buzzer", 32'(buzzer), 32'h0);
      check("rst_frame_tick", 32'(frame_tick), 32'h0);

      @(negedge clk) rst_n = 1'b1;
      digits = 16'h0042; blank_lz = 1'b1;
      run(2 * FRAME);
      blank_lz = 1'b0;
      run(FRAME);
      digits = 16'h00A0;
      run(FRAME + FRAME / 2);
      digits = 16'h1234;
      run(FRAME / 2 + 3);
      digits = 16'h9876;
      run(2 * FRAME);
      blink_mask = 4'b0001;
      run(6 * FRAME);

      // Pulse, then retrigger exactly as the count reaches 1, then a long held level.
      beep = 1'b1; run(1);
      beep = 1'b0; run(9);
      beep = 1'b1; run(1);
      beep = 1'b0; run(25);
      beep = 1'b1; run(40);
      beep = 1'b0; run(5);

      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 39) == 0) digits = rand_digits();
         if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 149) == 0) blink_mask = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 5) == 0) beep = ~beep;
         run(1);
      end

      beep = 1'b0; run(2);
      beep = 1'b1; run(1);
      beep = 1'b0; run(3);
      #2 rst_n = 1'b0;
      #1;
      check("midbeep_rst_buzzer", 32'(buzzer), 32'h0);
      check("midbeep_rst_common", 32'(common), 32'hF);
      check("midbeep_rst_seg", 32'(seg), 32'h0);
      run(3);
      rst_n = 1'b1;
      digits = 16'h0305; blank_lz = 1'b1; blink_mask = 4'b0100;
      run(5 * FRAME);

      run(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
